// File: rtl/regfile_wr_ctrl.sv
// rtl/regfile_wr_ctrl.sv - register file write-port sequencer: init clear, then round-robin ALU/load writeback
module regfile_wr_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              AluWrReq,
  input  logic [ADDR_W-1:0] AluWrAddr,
  input  logic [DATA_W-1:0] AluWrData,
  output logic              AluWrAck,
  input  logic              MemWrReq,
  input  logic [ADDR_W-1:0] MemWrAddr,
  input  logic [DATA_W-1:0] MemWrData,
  output logic              MemWrAck,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [DATA_W-1:0] DataIn,
  output logic              RegWr,
  output logic              Busy,
  output logic [CNT_W-1:0]  ConflictCnt
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  localparam logic [ADDR_W:0]  CLR_END = (ADDR_W+1)'(NREG);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                ptr_q, ptr_d;  // 0: ALU wins the next tie, 1: load wins
  logic                alu_ack_q, alu_ack_d;
  logic                mem_ack_q, mem_ack_d;
  logic                reg_wr_q, reg_wr_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   data_in_q, data_in_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    conflict_q, conflict_d;

  logic alu_elig, mem_elig, grant_alu, grant_mem;

  // A requester whose ack is still up was consumed on the previous edge.
  assign alu_elig  = AluWrReq && !alu_ack_q;
  assign mem_elig  = MemWrReq && !mem_ack_q;
  assign grant_alu = alu_elig && (!mem_elig || !ptr_q);
  assign grant_mem = mem_elig && (!alu_elig ||  ptr_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    alu_ack_d  = 1'b0;
    mem_ack_d  = 1'b0;
    reg_wr_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    data_in_d  = data_in_q;
    busy_d     = busy_q;
    conflict_d = conflict_q;
    case (state_q)
      ST_CLEAR: begin
        if (cnt_q == CLR_END) begin
          state_d = ST_RUN;
          busy_d  = 1'b0;
        end else begin
          reg_wr_d  = 1'b1;
          wr_addr_d = cnt_q[ADDR_W-1:0];
          data_in_d = '0;
          cnt_d     = cnt_q + 1'b1;
          busy_d    = 1'b1;
        end
      end
      ST_RUN: begin
        if (alu_elig && mem_elig && conflict_q != CNT_MAX)
          conflict_d = conflict_q + CNT_W'(1);
        if (grant_alu) begin
          alu_ack_d = 1'b1;
          wr_addr_d = AluWrAddr;
          data_in_d = AluWrData;
          reg_wr_d  = (AluWrAddr != '0);
          ptr_d     = 1'b1;
        end else if (grant_mem) begin
          mem_ack_d = 1'b1;
          wr_addr_d = MemWrAddr;
          data_in_d = MemWrData;
          reg_wr_d  = (MemWrAddr != '0);
          ptr_d     = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      ptr_q      <= 1'b0;
      alu_ack_q  <= 1'b0;
      mem_ack_q  <= 1'b0;
      reg_wr_q   <= 1'b0;
      wr_addr_q  <= '0;
      data_in_q  <= '0;
      busy_q     <= 1'b1;
      conflict_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      alu_ack_q  <= alu_ack_d;
      mem_ack_q  <= mem_ack_d;
      reg_wr_q   <= reg_wr_d;
      wr_addr_q  <= wr_addr_d;
      data_in_q  <= data_in_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign AluWrAck    = alu_ack_q;
  assign MemWrAck    = mem_ack_q;
  assign RegWr       = reg_wr_q;
  assign WrAddr      = wr_addr_q;
  assign DataIn      = data_in_q;
  assign Busy        = busy_q;
  assign ConflictCnt = conflict_q;

endmodule
